execute_stage_md: RTL
=====================

EXECUTE_STAGE_MD -- requirements
Module: execute_stage_md

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; legal values 32 and 64.
REQ-002 Parameter RADDR_W, default 5, destination-register index width.
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  in  1  reset; synchronous, active-high.
REQ-005 Ports RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE  in  1 each  decoded controls for the instruction in E.
REQ-006 Port ALUControlE  in  4  op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low XLEN), 11 DIVU, 12 REMU; 13-15 are treated as ADD.
REQ-007 Port BranchFunctE  in  3  branch condition: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU; 2 and 3 never take the branch.
REQ-008 Ports RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW  in  XLEN each  operands, immediate, PC values, write-back forward value.
REQ-009 Port RD_E  in  RADDR_W  destination register.
REQ-010 Ports ForwardA_E, ForwardB_E  in  2 each  operand select: 00 register, 01 ResultW, 10 ALU_ResultM, 11 register.
REQ-011 Port FlushE  in  1  kills the instruction in E.
REQ-012 Ports PCSrcE  out  1  and PCTargetE  out  XLEN  redirect request and target.
REQ-013 Port StallE  out  1  hazard unit holds F/D/E when high.
REQ-014 Ports RegWriteM, MemWriteM, ResultSrcM  out  1 each; RD_M  out  RADDR_W; PCPlus4M, WriteDataM, ALU_ResultM  out  XLEN each: E/M pipeline register.

Function
REQ-015 SrcB is the forwarded B operand when ALUSrcE=0 and Imm_Ext_E when ALUSrcE=1; WriteDataM always captures the forwarded B operand, never the immediate.
REQ-016 Single-cycle ops (ALUControlE 0-9, 13-15): result is registered into the M stage on the next edge; StallE stays 0.
REQ-017 Shift amount is SrcB[log2(XLEN)-1:0]; SLT/SLTU yield 1 or 0, zero-extended; all arithmetic wraps modulo 2^XLEN.
REQ-018 PCTargetE = PCE + Imm_Ext_E, truncated to XLEN bits.
REQ-019 PCSrcE = ~FlushE & (JumpE | (BranchE & branch condition on the forwarded A and B operands)); PCSrcE is combinational and is 0 while the FSM is in BUSY.
REQ-020 When JumpE=1, ALU_ResultM captures PCPlus4E (link value).
REQ-021 Multi-cycle ops (10-12) are driven by an FSM with states IDLE, BUSY and DONE.
REQ-022 IDLE to BUSY: on a MUL/DIVU/REMU in E with FlushE=0. In that cycle the block latches both forwarded operands, RD_E and the controls, loads the counter with XLEN-1, and drives StallE=1.
REQ-023 BUSY: one shift-add (MUL) or restoring-subtract (DIVU/REMU) iteration per cycle; StallE=1; the counter decrements; the FSM goes to DONE when the counter reads 0.
REQ-024 DONE: StallE=0; the next edge loads the latched result and controls into the M registers; the FSM returns to IDLE.
REQ-025 Timing: the op enters at cycle 0, StallE is high for cycles 0 through XLEN, and the result is visible on the M outputs at cycle XLEN+2.
REQ-026 While StallE=1, each edge loads a bubble into M: RegWriteM=0 and MemWriteM=0; the other M fields hold their previous values.
REQ-027 Divide by zero: DIVU returns all ones and REMU returns the dividend; the op still takes the full latency.
REQ-028 FlushE=1 in IDLE: the next edge loads a bubble into M. FlushE=1 in BUSY or DONE: the op is aborted, the FSM returns to IDLE, StallE falls in the same cycle, and a bubble is loaded.
REQ-029 Operands captured at issue are used for the whole op; later changes on ResultW, ALU_ResultM or the Forward selects have no effect on it.

Reset
REQ-030 When rst=1 at a clock edge, all M outputs go to 0, the FSM goes to IDLE and the counter clears; StallE is 0 from the cycle after that edge.
REQ-031 Reset asserted mid-operation discards the op; no result is ever written to M.

Verification
REQ-032 ADD: RD1=5, RD2=7, ForwardA=01 with ResultW=100 -> ALU_ResultM=107 one cycle later, StallE=0 throughout.
REQ-033 BLT: A=0xFFFFFFFF, B=1 -> PCSrcE=1. Same operands with BLTU -> PCSrcE=0. In both cases PCTargetE = PCE + Imm.
REQ-034 MUL 0x10000 x 0x10000 (XLEN=32): StallE high for exactly 33 cycles, ALU_ResultM=0, and RegWriteM=0 during the stall; with RegWriteE=1 at issue, RegWriteM=1 only at the result cycle.
REQ-035 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/7 -> 2; ResultW is changed during BUSY and the results are unaffected.
REQ-036 FlushE pulsed at BUSY cycle 5 -> StallE=0 in that cycle, bubble in M, FSM in IDLE; a following ADD completes normally.
REQ-037 rst pulsed at BUSY cycle 10 -> all M outputs 0 after the edge, StallE=0, and no stale result appears in later cycles.

Source files
------------

// File: rtl/execute_stage_md_if.sv
// Execute-stage bundle: decoded E-stage inputs, redirect/stall outputs and E/M register outputs.
interface execute_stage_md_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
);
    logic                RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE;
    logic [3:0]          ALUControlE;
    logic [2:0]          BranchFunctE;
    logic [XLEN-1:0]     RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [RADDR_W-1:0]  RD_E;
    logic [1:0]          ForwardA_E, ForwardB_E;
    logic                FlushE;

    logic                PCSrcE;
    logic [XLEN-1:0]     PCTargetE;
    logic                StallE;
    logic                RegWriteM, MemWriteM, ResultSrcM;
    logic [RADDR_W-1:0]  RD_M;
    logic [XLEN-1:0]     PCPlus4M, WriteDataM, ALU_ResultM;

    modport master (
        output RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE,
               ALUControlE, BranchFunctE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
               ResultW, RD_E, ForwardA_E, ForwardB_E, FlushE,
        input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
               RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );

    modport slave (
        input  RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE,
               ALUControlE, BranchFunctE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
               ResultW, RD_E, ForwardA_E, ForwardB_E, FlushE,
        output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
               RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );
endinterface

// File: rtl/execute_stage_md.sv
// Execute stage with forwarding, branch resolution, single-cycle ALU and an
// iterative MUL/DIVU/REMU unit that stalls the front end while it runs.
module execute_stage_md #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    execute_stage_md_if.slave  bus
);
    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0]    src_a, fwd_b, src_b, alu_res;
    logic               br_cond, is_md, issue, stall;

    logic [SHW-1:0]     cnt_q;
    logic [XLEN-1:0]    acc_q, x_q, y_q, acc_d, x_d, y_d;
    logic [XLEN:0]      rem_sh;
    logic               mul_q, quot_q, rw_q, mw_q, rs_q;
    logic [RADDR_W-1:0] rd_q;
    logic [XLEN-1:0]    pc4_q, wd_q;

    logic               rw_m, mw_m, rs_m;
    logic [RADDR_W-1:0] rd_m;
    logic [XLEN-1:0]    pc4_m, wd_m, res_m;

    always_comb begin
        case (bus.ForwardA_E)
            2'b01:   src_a = bus.ResultW;
            2'b10:   src_a = res_m;
            default: src_a = bus.RD1_E;
        endcase
        case (bus.ForwardB_E)
            2'b01:   fwd_b = bus.ResultW;
            2'b10:   fwd_b = res_m;
            default: fwd_b = bus.RD2_E;
        endcase
        src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
    end

    always_comb begin
        case (bus.ALUControlE)
            4'd1:    alu_res = src_a - src_b;
            4'd2:    alu_res = src_a & src_b;
            4'd3:    alu_res = src_a | src_b;
            4'd4:    alu_res = src_a ^ src_b;
            4'd5:    alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'd6:    alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            4'd7:    alu_res = src_a << src_b[SHW-1:0];
            4'd8:    alu_res = src_a >> src_b[SHW-1:0];
            4'd9:    alu_res = $signed(src_a) >>> src_b[SHW-1:0];
            default: alu_res = src_a + src_b;
        endcase
    end

    // Branches compare the forwarded operands, never the immediate.
    always_comb begin
        case (bus.BranchFunctE)
            3'd0:    br_cond = (src_a == fwd_b);
            3'd1:    br_cond = (src_a != fwd_b);
            3'd4:    br_cond = ($signed(src_a) <  $signed(fwd_b));
            3'd5:    br_cond = ($signed(src_a) >= $signed(fwd_b));
            3'd6:    br_cond = (src_a <  fwd_b);
            3'd7:    br_cond = (src_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase
    end

    assign is_md = (bus.ALUControlE == 4'd10) || (bus.ALUControlE == 4'd11) ||
                   (bus.ALUControlE == 4'd12);
    assign issue = (state_q == IDLE) && is_md && !bus.FlushE;
    assign stall = issue || ((state_q == BUSY) && !bus.FlushE);

    assign bus.StallE    = stall;
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
    assign bus.PCSrcE    = (state_q != BUSY) && !bus.FlushE &&
                           (bus.JumpE || (bus.BranchE && br_cond));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = BUSY;
            BUSY:    if (bus.FlushE) state_d = IDLE;
                     else if (cnt_q == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // One iteration: shift-add for MUL, restoring subtract for DIVU/REMU.
    // A zero divisor always "fits", which yields all-ones quotient and remainder = dividend.
    always_comb begin
        acc_d  = acc_q;
        x_d    = x_q;
        y_d    = y_q;
        rem_sh = {acc_q, x_q[XLEN-1]};
        if (mul_q) begin
            acc_d = acc_q + (y_q[0] ? x_q : '0);
            x_d   = {x_q[XLEN-2:0], 1'b0};
            y_d   = {1'b0, y_q[XLEN-1:1]};
        end else if (rem_sh >= {1'b0, y_q}) begin
            acc_d = XLEN'(rem_sh - {1'b0, y_q});
            x_d   = {x_q[XLEN-2:0], 1'b1};
        end else begin
            acc_d = rem_sh[XLEN-1:0];
            x_d   = {x_q[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mul_q   <= 1'b0;
            quot_q  <= 1'b0;
            rw_q    <= 1'b0;
            mw_q    <= 1'b0;
            rs_q    <= 1'b0;
            rd_q    <= '0;
            pc4_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                cnt_q  <= SHW'(XLEN-1);
                acc_q  <= '0;
                x_q    <= src_a;
                y_q    <= src_b;
                mul_q  <= (bus.ALUControlE == 4'd10);
                quot_q <= (bus.ALUControlE == 4'd11);
                rw_q   <= bus.RegWriteE;
                mw_q   <= bus.MemWriteE;
                rs_q   <= bus.ResultSrcE;
                rd_q   <= bus.RD_E;
                pc4_q  <= bus.PCPlus4E;
                wd_q   <= fwd_b;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q - SHW'(1);
                acc_q <= acc_d;
                x_q   <= x_d;
                y_q   <= y_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rw_m  <= 1'b0;
            mw_m  <= 1'b0;
            rs_m  <= 1'b0;
            rd_m  <= '0;
            pc4_m <= '0;
            wd_m  <= '0;
            res_m <= '0;
        end else if ((state_q == DONE) && !bus.FlushE) begin
            rw_m  <= rw_q;
            mw_m  <= mw_q;
            rs_m  <= rs_q;
            rd_m  <= rd_q;
            pc4_m <= pc4_q;
            wd_m  <= wd_q;
            res_m <= quot_q ? x_q : acc_q;
        end else if (stall || bus.FlushE) begin
            rw_m <= 1'b0;
            mw_m <= 1'b0;
        end else begin
            rw_m  <= bus.RegWriteE;
            mw_m  <= bus.MemWriteE;
            rs_m  <= bus.ResultSrcE;
            rd_m  <= bus.RD_E;
            pc4_m <= bus.PCPlus4E;
            wd_m  <= fwd_b;
            res_m <= bus.JumpE ? bus.PCPlus4E : alu_res;
        end
    end

    assign bus.RegWriteM   = rw_m;
    assign bus.MemWriteM   = mw_m;
    assign bus.ResultSrcM  = rs_m;
    assign bus.RD_M        = rd_m;
    assign bus.PCPlus4M    = pc4_m;
    assign bus.WriteDataM  = wd_m;
    assign bus.ALU_ResultM = res_m;
endmodule
